keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Sequencing controller for the 4x4 hex keypad.
- Drives the rows one-hot, samples the columns through a 2-flop synchronizer, and debounces press and release.
- Emits one key event per physical press.
- Keeps a two-digit history (newest, previous) that feeds the time-multiplexed seven-segment display path in the top level.

Parameters:
- SCAN_DIV, 6000, clk cycles each row stays driven during scanning (1 ms at 6 MHz).
- DEBOUNCE_CYCLES, 60000, cycles a press or release must stay stable before it is accepted (10 ms at 6 MHz).

Ports:
- clk  in  1  system clock (6 MHz in the top level).
- rst  in  1  synchronous, active-high reset.
- col_i  in  4  keypad columns, active-high, asynchronous to clk.
- row_o  out  4  one-hot row drive.
- key_o  out  4  hex code of the last accepted key.
- key_valid_o  out  1  one-cycle pulse when key_o updates.
- digit0_o  out  4  newest accepted key.
- digit1_o  out  4  previous accepted key.

Behaviour:
- Reset values:
  - row_o = 4'b0001
  - key_o = 0
  - key_valid_o = 0
  - digit0_o = digit1_o = 0
  - state = SCAN; all counters and synchronizer flops cleared.
- Reset asserted mid-operation aborts any debounce and emits no pulse.
- Synchronizer: col_s is col_i delayed by 2 clk. All decisions use col_s only.
- SCAN:
  - Row counter counts 0..SCAN_DIV-1. At terminal count, row_o rotates left (0001 -> 0010 -> 0100 -> 1000 -> 0001) and the counter clears.
  - If col_s != 0 and the row has been held at least 3 cycles (synchronizer settled): latch row_idx and col_idx, then go to PRESS_DB with the row frozen.
  - Multiple columns high: lowest set index wins.
- PRESS_DB:
  - Debounce counter increments while col_s[col_idx] = 1.
  - Any cycle with col_s[col_idx] = 0 -> return to SCAN with the same row and the row counter cleared; no event.
  - Counter reaches DEBOUNCE_CYCLES-1 -> go to HELD. On the same edge:
    - key_o <= keymap(row_idx, col_idx)
    - key_valid_o = 1 for exactly one cycle
    - digit1_o <= digit0_o
    - digit0_o <= key
- HELD:
  - Row stays frozen.
  - col_s[col_idx] = 0 -> go to RELEASE_DB with the counter cleared.
  - Other keys pressed in this state are ignored.
- RELEASE_DB:
  - Counter increments while col_s[col_idx] = 0.
  - Any 1 -> back to HELD (bounce); no new event.
  - Counter reaches DEBOUNCE_CYCLES-1 -> go to SCAN.
- Keymap, row-major, col0..col3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Counter widths: $clog2(max(SCAN_DIV, DEBOUNCE_CYCLES)). No wrap: counters clear on every state change.
- A held key never repeats; exactly one key_valid_o per press-release cycle.

Optional Feature:
- Macro: KEYSCAN_DEBUG_EN.
- When defined: adds output port debug_state_o [2:0], carrying the encoded state (SCAN=0, PRESS_DB=1, HELD=2, RELEASE_DB=3).
- When undefined: the port is absent; function is otherwise identical.

Decomposition:
- Package keypad_pkg holds:
  - the enum kp_state_t
  - constant KEYMAP (4x4 array of 4-bit codes)
  - localparams NUM_ROWS = 4 and NUM_COLS = 4
- One sub-module: kp_sync, a 2-flop synchronizer parameterized by width, with synchronous active-high reset.

Test Plan (bench uses SCAN_DIV=8, DEBOUNCE_CYCLES=20; bench drives col_i from row_o to model the switch matrix):
- Reset held 5 cycles, then released -> row_o = 0001, digits 0/0, no pulse; row_o cycles through all four rows every 32 cycles.
- Key (row0, col3) pressed steadily -> exactly one pulse; key_o = A; digit0 = A; digit1 = 0.
- Then key (row1, col1) -> key_o = 5; digit0 = 5; digit1 = A; holding it 200 cycles produces no further pulses.
- Press that bounces, e.g. col high 10 cycles, low 1, high 25 -> exactly one pulse, arriving 20 cycles after the last rising edge (plus 2 synchronizer cycles); a 10-cycle glitch alone produces no pulse.
- Release bounce (low 5, high 2, low 25) -> still one event; state returns to SCAN only after 20 stable low cycles.
- rst asserted during PRESS_DB -> no pulse; outputs return to reset values on the next edge. Two keys in the same row (col1 and col2) -> code for col1 only.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_t;

  // Row-major key legend as printed on the keypad.
  localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--)
      if (v[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module kp_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_ff1;
  logic [W-1:0] r_ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff1 <= '0;
      r_ff2 <= '0;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad row scanner with press/release debounce and two-digit key history.
// Define KEYSCAN_DEBUG_EN to expose the FSM state on debug_state_o.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 6000,
  parameter int DEBOUNCE_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic [3:0] digit0_o,
`ifdef KEYSCAN_DEBUG_EN
  output logic [3:0] digit1_o,
  output logic [2:0] debug_state_o
`else
  output logic [3:0] digit1_o
`endif
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_COLS-1:0] w_col_s;
  logic                w_hit;

  kp_state_t           r_state;
  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_settle;
  logic [NUM_ROWS-1:0] r_row;
  logic [1:0]          r_row_idx;
  logic [1:0]          r_col_idx;
  logic [3:0]          r_key;
  logic                r_vld;
  logic [3:0]          r_d0;
  logic [3:0]          r_d1;

  kp_sync #(.W(NUM_COLS)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (col_i),
    .o_q (w_col_s)
  );

  assign w_hit = w_col_s[r_col_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SCAN;
      r_cnt     <= '0;
      r_settle  <= '0;
      r_row     <= 4'b0001;
      r_row_idx <= '0;
      r_col_idx <= '0;
      r_key     <= '0;
      r_vld     <= 1'b0;
      r_d0      <= '0;
      r_d1      <= '0;
    end else begin
      r_vld <= 1'b0;
      // Counts how long the current row has been driven; saturates once the
      // synchronizer output reflects this row.
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      case (r_state)
        SCAN: begin
          if (w_col_s != '0 && r_settle == 2'd2) begin
            r_row_idx <= lowest_set(r_row);
            r_col_idx <= lowest_set(w_col_s);
            r_cnt     <= '0;
            r_state   <= PRESS_DB;
          end else if (r_cnt == SCAN_LAST) begin
            r_row    <= {r_row[NUM_ROWS-2:0], r_row[NUM_ROWS-1]};
            r_cnt    <= '0;
            r_settle <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESS_DB: begin
          if (!w_hit) begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end else if (r_cnt == DB_LAST) begin
            r_cnt   <= '0;
            r_state <= HELD;
            r_key   <= KEYMAP[r_row_idx][r_col_idx];
            r_vld   <= 1'b1;
            r_d1    <= r_d0;
            r_d0    <= KEYMAP[r_row_idx][r_col_idx];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!w_hit) begin
            r_cnt   <= '0;
            r_state <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (w_hit) begin
            r_cnt   <= '0;
            r_state <= HELD;
          end else if (r_cnt == DB_LAST) begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= SCAN;
        end
      endcase
    end
  end

  assign row_o       = r_row;
  assign key_o       = r_key;
  assign key_valid_o = r_vld;
  assign digit0_o    = r_d0;
  assign digit1_o    = r_d1;
`ifdef KEYSCAN_DEBUG_EN
  assign debug_state_o = {1'b0, r_state};
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench: switch matrix model driving col_i from row_o, event-level reference.
module tb_keypad_scan_ctrl;

  localparam int SD = 8;
  localparam int DB = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_i;
  logic [3:0] row_o, key_o, digit0_o, digit1_o;
  logic       key_valid_o;
`ifdef KEYSCAN_DEBUG_EN
  logic [2:0] debug_state_o;
`endif

  logic [3:0][3:0] pressed = '0;  // pressed[row][col]
  logic [3:0] km [16];
  logic [3:0] exp_d0 = '0, exp_d1 = '0;
  logic [3:0] p_key = '0, p_d0 = '0, p_d1 = '0;
  int errors = 0, checks = 0;
  int cyc = 0, pulses = 0, pulse_cyc = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_i       (col_i),
    .row_o       (row_o),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .digit0_o    (digit0_o),
`ifdef KEYSCAN_DEBUG_EN
    .digit1_o    (digit1_o),
    .debug_state_o(debug_state_o)
`else
    .digit1_o    (digit1_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    col_i = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_o[r] && pressed[r][c]) col_i[c] = 1'b1;
  end

  always @(negedge clk) begin
    if (key_valid_o === 1'b1) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc;
      p_key     <= key_o;
      p_d0      <= digit0_o;
      p_d1      <= digit1_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until scanning has just moved onto row r.
  task automatic wait_row(input int r);
    for (int k = 0; k < 40 && row_o[r]; k++) @(negedge clk);
    for (int k = 0; k < 40 && !row_o[r]; k++) @(negedge clk);
    chk("row_reach", 32'(row_o[r]), 32'd1);
  endtask

  task automatic accept(input logic [3:0] code);
    exp_d1 = exp_d0;
    exp_d0 = code;
  endtask

  task automatic check_event(input string tag, input logic [3:0] code);
    chk({tag, "_key"}, 32'(p_key), 32'(code));
    chk({tag, "_dig0"}, 32'(p_d0), 32'(exp_d0));
    chk({tag, "_dig1"}, 32'(p_d1), 32'(exp_d1));
  endtask

  task automatic press_key(input string tag, input int r, input int c, input int hold);
    int p0;
    logic [3:0] code;
    code = km[r*4 + c];
    p0 = pulses;
    pressed[r][c] = 1'b1;
    for (int k = 0; k < 100 && pulses == p0; k++) @(negedge clk);
    tick(1);
    chk({tag, "_pulse"}, 32'(pulses - p0), 32'd1);
    accept(code);
    check_event(tag, code);
    tick(hold);
    pressed[r][c] = 1'b0;
    tick(40);
    chk({tag, "_single"}, 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    int p0, t_rise, t_fall, last, glen, rr, cc;
    logic [3:0] prev, nxt;
    km = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
           4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    // Reset and idle scanning
    rst = 1'b1;
    tick(5);
    chk("rst_row", 32'(row_o), 32'h1);
    chk("rst_key", 32'(key_o), 32'h0);
    chk("rst_vld", 32'(key_valid_o), 32'h0);
    chk("rst_dig0", 32'(digit0_o), 32'h0);
    chk("rst_dig1", 32'(digit1_o), 32'h0);
    rst = 1'b0;
    prev = row_o;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 20 && row_o == prev; k++) @(negedge clk);
      nxt = 4'((prev << 1) | (prev >> 3));
      chk("rot_val", 32'(row_o), 32'(nxt));
      if (i > 0) chk("rot_period", 32'(cyc - last), 32'(SD));
      last = cyc;
      prev = row_o;
    end
    chk("rot_full_cycle", 32'(row_o), 32'h1);
    chk("idle_no_pulse", 32'(pulses), 32'd0);

    // Basic presses, long hold must not repeat
    press_key("keyA", 0, 3, 30);
    press_key("key5", 1, 1, 200);

    // Glitches shorter than debounce produce nothing
    p0 = pulses;
    wait_row(2);
    pressed[2][1] = 1'b1; tick(10); pressed[2][1] = 1'b0;
    tick(40);
    chk("glitch10", 32'(pulses - p0), 32'd0);
    glen = $urandom_range(1, 18);
    rr = $urandom_range(0, 3);
    cc = $urandom_range(0, 3);
    wait_row(rr);
    pressed[rr][cc] = 1'b1; tick(glen); pressed[rr][cc] = 1'b0;
    tick(40);
    chk("glitch_rand", 32'(pulses - p0), 32'd0);

    // Bouncing press: pulse lands 2 sync + DB cycles after the final rising sample
    p0 = pulses;
    wait_row(2);
    pressed[2][0] = 1'b1; tick(10);
    pressed[2][0] = 1'b0; tick(1);
    pressed[2][0] = 1'b1;
    t_rise = cyc;
    tick(25);
    chk("bounce_pulse", 32'(pulses - p0), 32'd1);
    chk("bounce_time", 32'(pulse_cyc), 32'(t_rise + 1 + 2 + DB));
    accept(4'h7);
    check_event("bounce", 4'h7);

    // Bouncing release: scanning resumes DB stable-low cycles later, then a full row period
    pressed[2][0] = 1'b0; tick(5);
    pressed[2][0] = 1'b1; tick(2);
    pressed[2][0] = 1'b0;
    t_fall = cyc;
    for (int k = 0; k < 100 && cyc < t_fall + 1 + 2 + DB + SD - 1; k++) @(negedge clk);
    chk("rel_frozen", 32'(row_o), 32'h4);
    tick(1);
    chk("rel_resume", 32'(row_o), 32'h8);
    chk("rel_single", 32'(pulses - p0), 32'd1);

    // Reset during press debounce
    p0 = pulses;
    wait_row(3);
    pressed[3][3] = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_row", 32'(row_o), 32'h1);
    chk("mid_rst_key", 32'(key_o), 32'h0);
    chk("mid_rst_dig0", 32'(digit0_o), 32'h0);
    chk("mid_rst_dig1", 32'(digit1_o), 32'h0);
    pressed[3][3] = 1'b0;
    exp_d0 = '0;
    exp_d1 = '0;
    tick(2);
    rst = 1'b0;
    tick(40);
    chk("mid_rst_no_pulse", 32'(pulses - p0), 32'd0);

    // Two keys in one row: lower column wins
    p0 = pulses;
    pressed[1][1] = 1'b1;
    pressed[1][2] = 1'b1;
    for (int k = 0; k < 100 && pulses == p0; k++) @(negedge clk);
    tick(1);
    chk("dual_pulse", 32'(pulses - p0), 32'd1);
    accept(4'h5);
    check_event("dual", 4'h5);
    pressed = '0;
    tick(40);

    // Random presses against the history model
    for (int i = 0; i < 6; i++)
      press_key("rand", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 60));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
